// File: rtl/mem_map_pkg.sv
// Shared definitions for the memory region decoder: FSM encoding, default region map, fault counter width.
package mem_map_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FAULT_CNT_W = 8;
  localparam int WAIT_W      = 4;

  // Region 0 occupies the least significant slice of every table.
  localparam logic [4*32-1:0] DEF_REG_BASE  = {32'hFFFF0000, 32'h0000B800, 32'h7FFFEFFC, 32'h10010000};
  localparam logic [4*32-1:0] DEF_REG_LIMIT = {32'hFFFF000F, 32'h0000CABF, 32'h7FFFFFFB, 32'h10010FFF};
  localparam logic [4*13-1:0] DEF_REG_OFFS  = {13'h0000, 13'h0000, 13'h1000, 13'h0000};
  localparam logic [4*4-1:0]  DEF_REG_WAIT  = {4'd3, 4'd2, 4'd1, 4'd0};

  function automatic logic [FAULT_CNT_W-1:0] fault_sat_inc(input logic [FAULT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Combinational region lookup: per-region range compare, lowest-index priority, physical translation.
// Zero latency; no flow control of its own.
module mem_region_match
  import mem_map_pkg::*;
#(
  parameter int                       ADDR_W    = 32,
  parameter int                       PADDR_W   = 13,
  parameter int                       NREG      = 4,
  parameter logic [NREG*ADDR_W-1:0]   REG_BASE  = DEF_REG_BASE,
  parameter logic [NREG*ADDR_W-1:0]   REG_LIMIT = DEF_REG_LIMIT,
  parameter logic [NREG*PADDR_W-1:0]  REG_OFFS  = DEF_REG_OFFS,
  parameter logic [NREG*WAIT_W-1:0]   REG_WAIT  = DEF_REG_WAIT,
  localparam int                      MB_W      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               hit_o,
  output logic [NREG-1:0]    me_o,
  output logic [MB_W-1:0]    mb_o,
  output logic [PADDR_W-1:0] pad_o,
  output logic [WAIT_W-1:0]  wait_o
);

  logic [NREG-1:0]    hit_vec;
  logic [PADDR_W-1:0] pad_vec [NREG];

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam logic [ADDR_W-1:0]  BASE  = REG_BASE[r*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0]  LIMIT = REG_LIMIT[r*ADDR_W +: ADDR_W];
    localparam logic [PADDR_W-1:0] OFFS  = REG_OFFS[r*PADDR_W +: PADDR_W];
    logic [ADDR_W-1:0] delta;

    assign hit_vec[r] = (addr_i >= BASE) && (addr_i <= LIMIT);
    assign delta      = addr_i - BASE;
    // Only the low bits of the offset-into-region survive truncation to PADDR_W.
    assign pad_vec[r] = delta[PADDR_W-1:0] + OFFS;
  end

  // Walk from the highest index down so the lowest hitting region is written last.
  always_comb begin
    hit_o  = 1'b0;
    me_o   = '0;
    mb_o   = '0;
    pad_o  = '0;
    wait_o = '0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if (hit_vec[r]) begin
        hit_o    = 1'b1;
        me_o     = '0;
        me_o[r]  = 1'b1;
        mb_o     = MB_W'(r);
        pad_o    = pad_vec[r];
        wait_o   = REG_WAIT[r*WAIT_W +: WAIT_W];
      end
    end
  end

endmodule

// File: rtl/mem_region_decoder.sv
// Accepts one access at a time, decodes it to a region, inserts the region's wait states, then presents the response.
// Latency 1+W cycles from acceptance; req_ready is low until the response handshake completes.
module mem_region_decoder
  import mem_map_pkg::*;
#(
  parameter int                       ADDR_W    = 32,
  parameter int                       PADDR_W   = 13,
  parameter int                       NREG      = 4,
  parameter logic [NREG*ADDR_W-1:0]   REG_BASE  = DEF_REG_BASE,
  parameter logic [NREG*ADDR_W-1:0]   REG_LIMIT = DEF_REG_LIMIT,
  parameter logic [NREG*PADDR_W-1:0]  REG_OFFS  = DEF_REG_OFFS,
  parameter logic [NREG*WAIT_W-1:0]   REG_WAIT  = DEF_REG_WAIT,
  localparam int                      MB_W      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_wr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PADDR_W-1:0]     rsp_pad,
  output logic [NREG-1:0]        rsp_me,
  output logic [MB_W-1:0]        rsp_mb,
  output logic                   rsp_wr,
  output logic                   rsp_iad,
  output logic [ADDR_W-1:0]      fault_addr,
  output logic [FAULT_CNT_W-1:0] fault_cnt,
  input  logic                   fault_clr
);

  logic               m_hit;
  logic [NREG-1:0]    m_me;
  logic [MB_W-1:0]    m_mb;
  logic [PADDR_W-1:0] m_pad;
  logic [WAIT_W-1:0]  m_wait;

  mem_region_match #(
    .ADDR_W    (ADDR_W),
    .PADDR_W   (PADDR_W),
    .NREG      (NREG),
    .REG_BASE  (REG_BASE),
    .REG_LIMIT (REG_LIMIT),
    .REG_OFFS  (REG_OFFS),
    .REG_WAIT  (REG_WAIT)
  ) u_match (
    .addr_i (req_addr),
    .hit_o  (m_hit),
    .me_o   (m_me),
    .mb_o   (m_mb),
    .pad_o  (m_pad),
    .wait_o (m_wait)
  );

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [PADDR_W-1:0] pad_q, pad_d;
  logic [NREG-1:0]    me_q, me_d;
  logic [MB_W-1:0]    mb_q, mb_d;
  logic               wr_q, wr_d;
  logic               iad_q, iad_d;
  logic [ADDR_W-1:0]      faddr_q, faddr_d;
  logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   accept;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pad_q   <= '0;
      me_q    <= '0;
      mb_q    <= '0;
      wr_q    <= 1'b0;
      iad_q   <= 1'b0;
      faddr_q <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      me_q    <= me_d;
      mb_q    <= mb_d;
      wr_q    <= wr_d;
      iad_q   <= iad_d;
      faddr_q <= faddr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pad_d   = pad_q;
    me_d    = me_q;
    mb_d    = mb_q;
    wr_d    = wr_q;
    iad_d   = iad_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // The matcher already zeroes pad/me/mb/wait on a miss, so a miss lands in RESP.
          pad_d   = m_pad;
          me_d    = m_me;
          mb_d    = m_mb;
          wr_d    = req_wr;
          iad_d   = !m_hit;
          cnt_d   = m_wait;
          state_d = (m_wait != '0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= WAIT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A miss accepted alongside a clear is treated as the first fault after the clear.
  always_comb begin
    faddr_d = faddr_q;
    fcnt_d  = fcnt_q;
    if (accept && !m_hit) begin
      if (fault_clr || (fcnt_q == '0)) begin
        faddr_d = req_addr;
        fcnt_d  = FAULT_CNT_W'(1);
      end else begin
        fcnt_d  = fault_sat_inc(fcnt_q);
      end
    end else if (fault_clr) begin
      faddr_d = '0;
      fcnt_d  = '0;
    end
  end

  assign rsp_pad    = pad_q;
  assign rsp_me     = me_q;
  assign rsp_mb     = mb_q;
  assign rsp_wr     = wr_q;
  assign rsp_iad    = iad_q;
  assign fault_addr = faddr_q;
  assign fault_cnt  = fcnt_q;

endmodule

// File: tb/tb_mem_region_decoder.sv
// Randomized and directed checks of mem_region_decoder against a table-driven reference model.
module tb_mem_region_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [12:0] rsp_pad;
  logic [3:0]  rsp_me;
  logic [1:0]  rsp_mb;
  logic        rsp_wr;
  logic        rsp_iad;
  logic [31:0] fault_addr;
  logic [7:0]  fault_cnt;
  logic        fault_clr;

  int n_total = 0;
  int n_bad   = 0;

  // Reference region map, region 0 first.
  bit [31:0] ref_base  [4] = '{32'h10010000, 32'h7FFFEFFC, 32'h0000B800, 32'hFFFF0000};
  bit [31:0] ref_limit [4] = '{32'h10010FFF, 32'h7FFFFFFB, 32'h0000CABF, 32'hFFFF000F};
  bit [31:0] ref_offs  [4] = '{32'h0, 32'h1000, 32'h0, 32'h0};
  int        ref_wait  [4] = '{0, 1, 2, 3};

  bit [31:0] m_faddr = 0;
  int        m_fcnt  = 0;

  always #5 clk = ~clk;

  mem_region_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wr     (req_wr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_pad    (rsp_pad),
    .rsp_me     (rsp_me),
    .rsp_mb     (rsp_mb),
    .rsp_wr     (rsp_wr),
    .rsp_iad    (rsp_iad),
    .fault_addr (fault_addr),
    .fault_cnt  (fault_cnt),
    .fault_clr  (fault_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int find_region(input bit [31:0] a);
    for (int r = 0; r < 4; r++)
      if (a >= ref_base[r] && a <= ref_limit[r]) return r;
    return -1;
  endfunction

  // One complete transaction; inputs change only on the falling edge.
  task automatic do_access(input bit [31:0] a, input bit wr, input int hold, input bit clr);
    int        r, w, k;
    bit [12:0] e_pad;
    bit [3:0]  e_me;
    bit [1:0]  e_mb;
    bit        e_iad;
    r = find_region(a);
    if (r >= 0) begin
      w     = ref_wait[r];
      e_pad = 13'((a - ref_base[r]) + ref_offs[r]);
      e_me  = 4'(1 << r);
      e_mb  = 2'(r);
      e_iad = 1'b0;
    end else begin
      w = 0; e_pad = '0; e_me = '0; e_mb = '0; e_iad = 1'b1;
      if (clr || m_fcnt == 0) begin
        m_faddr = a;
        m_fcnt  = 1;
      end else if (m_fcnt < 255) begin
        m_fcnt++;
      end
    end
    if (r >= 0 && clr) begin
      m_faddr = 0;
      m_fcnt  = 0;
    end

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_wr = wr; fault_clr = clr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; fault_clr = 1'b0; req_addr = $urandom; req_wr = $urandom_range(0, 1);
    k = 1;
    while (!rsp_valid && k < 40) begin
      if (req_ready) check("req_ready_busy", req_ready, 0);
      @(negedge clk);
      k++;
    end
    check("latency", k, 1 + w);
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("req_ready_resp", req_ready, 0);
      check("rsp_pad", rsp_pad, e_pad);
      check("rsp_me", rsp_me, e_me);
      check("rsp_mb", rsp_mb, e_mb);
      check("rsp_iad", rsp_iad, e_iad);
      check("rsp_wr", rsp_wr, wr);
      check("fault_addr", fault_addr, m_faddr);
      check("fault_cnt", fault_cnt, m_fcnt);
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    bit [31:0] a;
    int        sel, r, k;
    bit        seen;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0;
    rsp_ready = 1'b0; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_pad", rsp_pad, 0);
    check("rst_rsp_me", rsp_me, 0);
    check("rst_rsp_mb", rsp_mb, 0);
    check("rst_rsp_iad", rsp_iad, 0);
    check("rst_rsp_wr", rsp_wr, 0);
    check("rst_fault_addr", fault_addr, 0);
    check("rst_fault_cnt", fault_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    do_access(32'h10010004, 1'b0, 0, 1'b0);
    do_access(32'h7FFFEFFC, 1'b1, 0, 1'b0);
    do_access(32'h0000CABF, 1'b0, 5, 1'b0);
    do_access(32'h00000000, 1'b0, 0, 1'b0);
    do_access(32'h20000000, 1'b1, 1, 1'b0);
    check("two_miss_cnt", fault_cnt, 2);
    check("two_miss_addr", fault_addr, 32'h00000000);
    for (int i = 0; i < 300; i++) do_access(32'h20000000 + i, 1'b0, 0, 1'b0);
    check("sat_cnt", fault_cnt, 255);
    check("sat_addr", fault_addr, 32'h00000000);
    do_access(32'hFFFF0010, 1'b0, 0, 1'b1);
    check("clr_miss_addr", fault_addr, 32'hFFFF0010);
    check("clr_miss_cnt", fault_cnt, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    m_faddr = 0; m_fcnt = 0;
    check("clr_only_addr", fault_addr, 0);
    check("clr_only_cnt", fault_cnt, 0);

    // Boundary and random traffic
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 5);
      r   = $urandom_range(0, 3);
      case (sel)
        0: a = ref_base[r];
        1: a = ref_limit[r];
        2: a = ref_base[r] - 1;
        3: a = ref_limit[r] + 1;
        4: a = ref_base[r] + $urandom_range(0, ref_limit[r] - ref_base[r]);
        default: a = $urandom;
      endcase
      do_access(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
    end

    // Reset in the second wait cycle of a 3-wait access drops it silently
    check("pre_rst_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = 32'hFFFF0000; req_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midwait_rsp_valid", rsp_valid, 0);
    check("midwait_fault_cnt", fault_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midwait_no_rsp", seen, 0);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_me", rsp_me, 0);
    m_faddr = 0; m_fcnt = 0;
    do_access(32'h10010FFF, 1'b1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
